uart_frame_receiver: RTL

UART_FRAME_RECEIVER -- requirements
Module: uart_frame_receiver

---
 rtl/uart_frame_receiver_pkg.sv | 28 ++
 rtl/uart_frame_receiver_if.sv | 28 ++
 rtl/uart_frame_receiver_baud_tick_gen.sv | 43 ++++
 rtl/uart_frame_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_receiver_pkg.sv
// Shared definitions for the UART receive path (also used by the transmit-side blocks).
package uart_frame_receiver_pkg;

    // Oversampling factor of the bit-timing tick relative to the baud rate.
    localparam int OVERSAMPLE = 16;

    // Tick-counter positions within one bit period.
    localparam logic [3:0] TICK_VOTE_A = 4'd7;
    localparam logic [3:0] TICK_VOTE_B = 4'd8;
    localparam logic [3:0] TICK_VOTE_C = 4'd9;
    localparam logic [3:0] TICK_LAST   = 4'd15;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // 2-of-3 vote over the three mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Serial line and received-byte signals of the UART frame receiver.
// master: the receiver (samples rxd, drives the result signals).
// slave : line driver / byte consumer.
interface uart_frame_receiver_if;

    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rxd,
        output rx_data,
        output rx_ready,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rxd,
        input  rx_data,
        input  rx_ready,
        input  frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/uart_frame_receiver_baud_tick_gen.sv
// Phase-accumulator tick generator: emits FACTOR ticks per bit period on average.
// The accumulator adds FACTOR*BAUD every clock and wraps at CLK_FREQ, so the tick
// rate is exact over time without needing an integer clock divider.
module baud_tick_gen #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200,
    parameter int FACTOR   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [32:0] INC   = 33'(longint'(FACTOR) * longint'(BAUD));
    localparam logic [32:0] LIMIT = 33'(longint'(CLK_FREQ));

    logic [31:0] acc;
    logic [32:0] sum;

    // One bit of headroom so the compare cannot be fooled by a wrap.
    always_comb begin
        sum = {1'b0, acc} + INC;
    end

    // Accumulate; on overflow past CLK_FREQ keep the remainder and pulse tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= LIMIT) begin
            acc  <= 32'(sum - LIMIT);
            tick <= 1'b1;
        end else begin
            acc  <= sum[31:0];
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 mid-bit voting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a synchronized 1->0 edge
// START     | confirming start bit at mid-bit; high there = glitch
// DATA      | voting and shifting in 8 data bits, LSB first
// STOP      | voting the stop bit; high = byte out, low = framing error
// WAIT_IDLE | after a framing error, waiting for the line to go high
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_frame_receiver_if.master  bus
);

    rx_state_t   state;
    rx_state_t   state_n;

    logic [1:0]  sync_q;
    logic        rxd_s;
    logic        rxd_d;
    logic        start_edge;

    logic        tick;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  samp;
    logic [7:0]  shreg;

    logic [7:0]  data_q;
    logic        ready_q;
    logic        ferr_q;

    logic        tick_mid;
    logic        tick_vote;
    logic        tick_wrap;
    logic        maj;
    logic        cnt_clr;
    logic        shift_en;
    logic        load_data;
    logic        ready_n;
    logic        ferr_n;

    assign rxd_s      = sync_q[1];
    assign start_edge = rxd_d & ~rxd_s;
    assign tick_mid   = tick && (tick_cnt == TICK_VOTE_A);
    assign tick_vote  = tick && (tick_cnt == TICK_VOTE_C);
    assign tick_wrap  = tick && (tick_cnt == TICK_LAST);

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .FACTOR   (OVERSAMPLE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clr),
        .tick  (tick)
    );

    // Two-flop synchronizer plus one delay flop for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            rxd_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], bus.rxd};
            rxd_d  <= rxd_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath strobes. The tick counter is not reset at mid-start:
    // letting it run to its wrap keeps count 0 on each bit boundary, so the
    // 7/8/9 votes of every later bit fall in the middle of that bit.
    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_data = 1'b0;
        ready_n   = 1'b0;
        ferr_n    = 1'b0;
        maj       = majority3(samp[0], samp[1], rxd_s);
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_n = ST_START;
                    cnt_clr = 1'b1;
                end
            end
            ST_START: begin
                if (tick_mid && rxd_s) begin
                    state_n = ST_IDLE;
                end else if (tick_wrap) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                shift_en = tick_vote;
                if (tick_wrap && (bit_cnt == LAST_DATA_BIT)) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop gives half a bit of margin for the next start edge.
                if (tick_vote) begin
                    if (maj) begin
                        load_data = 1'b1;
                        ready_n   = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        ferr_n    = 1'b1;
                        state_n   = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Tick and bit counters; both restart on an accepted start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_clr) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if ((state == ST_DATA) && (tick_cnt == TICK_LAST)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Hold the first two votes; the third is taken live at tick 9.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
        end else if (tick) begin
            if (tick_cnt == TICK_VOTE_A) begin
                samp[0] <= rxd_s;
            end
            if (tick_cnt == TICK_VOTE_B) begin
                samp[1] <= rxd_s;
            end
        end
    end

    // LSB-first shift: each voted bit enters at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {maj, shreg[7:1]};
        end
    end

    // Registered outputs: byte hold register and the two single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ready_q <= ready_n;
            ferr_q  <= ferr_n;
            if (load_data) begin
                data_q <= shreg;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_ready  = ready_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state != ST_IDLE);

endmodule
